// File: rtl/ltc_lvds_pkg.sv
// rtl/ltc_lvds_pkg.sv - shared constants and lane bit-pair helper for the LTC DDR LVDS emulator
package ltc_lvds_pkg;

   localparam int DW = 16;
   localparam int SLOTS = 8;
   localparam logic [DW-1:0] IDLE_WORD_DEF = '0;

   // Pair k of a word: lane A gets the even-position (from MSB) bit, lane B the next one.
   function automatic logic [1:0] lane_bits(input logic [DW-1:0] word, input logic [2:0] slot);
      logic [3:0] ia;
      logic [3:0] ib;
      ia = 4'(DW - 1) - {slot, 1'b0};
      ib = ia - 4'd1;
      lane_bits = {word[ia], word[ib]};
   endfunction

endpackage

// File: rtl/ltc_tx_holdbuf.sv
// rtl/ltc_tx_holdbuf.sv - one-entry valid/ready holding register, emptied by a drain strobe
module ltc_tx_holdbuf
   import ltc_lvds_pkg::*;
(
   input  logic          sys_clk,
   input  logic          reset,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic          en,
   input  logic          drain,
   output logic [DW-1:0] buf_data,
   output logic          buf_full
);

   logic ready_q;

   assign s_ready = ready_q & en;

   // Drain is only raised while full, so it can never collide with an accept.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         buf_full <= 1'b0;
         ready_q  <= 1'b1;
         buf_data <= '0;
      end else if (drain) begin
         buf_full <= 1'b0;
         ready_q  <= 1'b1;
      end else if (s_valid && s_ready) begin
         buf_full <= 1'b1;
         ready_q  <= 1'b0;
         buf_data <= s_data;
      end
   end

endmodule

// File: rtl/ltc_lvds_tx.sv
// rtl/ltc_lvds_tx.sv - LTC two-lane DDR LVDS transmitter emulator with frame slip
// Optional test-pattern source enabled by defining LTC_TX_TEST_PATTERN_EN.
module ltc_lvds_tx
   import ltc_lvds_pkg::*;
#(
   parameter logic [DW-1:0] IDLE_WORD = IDLE_WORD_DEF
) (
   input  logic          sys_clk,
   input  logic          reset,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic          slip,
`ifdef LTC_TX_TEST_PATTERN_EN
   input  logic          pattern_en,
   input  logic [DW-1:0] pattern,
`endif
   output logic          out_a,
   output logic          out_b,
   output logic          dco,
   output logic          fr,
   output logic          frame_start,
   output logic [2:0]    offset,
   output logic [15:0]   underflow_cnt
);

   logic [2:0]    slot_cnt;
   logic [DW-1:0] cur, prev, cur_nxt, prev_nxt;
   logic [DW-1:0] buf_data, pat_word;
   logic          buf_full, drain, load, slip_pend, use_pat, underrun;
   logic [2:0]    offset_nxt, pidx;
   logic [1:0]    pair;

`ifdef LTC_TX_TEST_PATTERN_EN
   assign use_pat  = pattern_en;
   assign pat_word = pattern;
`else
   assign use_pat  = 1'b0;
   assign pat_word = IDLE_WORD;
`endif

   assign load = (slot_cnt == 3'd0);

   ltc_tx_holdbuf u_holdbuf (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .en       (~use_pat),
      .drain    (drain),
      .buf_data (buf_data),
      .buf_full (buf_full)
   );

   // Outputs are computed from next-state values so a load appears on the pins one cycle later.
   always_comb begin
      prev_nxt   = prev;
      cur_nxt    = cur;
      offset_nxt = offset;
      drain      = 1'b0;
      underrun   = 1'b0;
      if (load) begin
         prev_nxt   = cur;
         offset_nxt = offset + {2'b00, slip_pend | slip};
         if (use_pat) begin
            cur_nxt = pat_word;
         end else if (buf_full) begin
            cur_nxt = buf_data;
            drain   = 1'b1;
         end else begin
            cur_nxt  = IDLE_WORD;
            underrun = 1'b1;
         end
      end
      // Slots before the offset replay the tail of the previous word.
      pidx = slot_cnt - offset_nxt;
      pair = (slot_cnt < offset_nxt) ? lane_bits(prev_nxt, pidx) : lane_bits(cur_nxt, pidx);
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         slot_cnt      <= 3'd0;
         cur           <= IDLE_WORD;
         prev          <= IDLE_WORD;
         offset        <= 3'd0;
         slip_pend     <= 1'b0;
         underflow_cnt <= 16'd0;
         out_a         <= 1'b0;
         out_b         <= 1'b0;
         dco           <= 1'b0;
         fr            <= 1'b0;
         frame_start   <= 1'b0;
      end else begin
         slot_cnt  <= slot_cnt + 3'd1;
         cur       <= cur_nxt;
         prev      <= prev_nxt;
         offset    <= offset_nxt;
         slip_pend <= load ? 1'b0 : (slip_pend | slip);
         if (underrun && underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 16'd1;
         {out_a, out_b} <= pair;
         dco            <= ~slot_cnt[0];
         fr             <= (slot_cnt < 3'(SLOTS / 2));
         frame_start    <= load;
      end
   end

endmodule

// File: doc/ltc_lvds_tx.md
Name: ltc_lvds_tx

Overview:
- Emulates the LTC ADC two-lane DDR LVDS output: serializes 16-bit samples onto lanes out_a/out_b, with a frame clock (fr) and a bit clock (dco).
- Drives the sp605 ISERDES receiver in loopback/self-test builds and serves as a cycle-accurate stimulus source for receiver benches.
- One sys_clk cycle is one DDR bit slot (half a DCO period); one frame is 8 slots.
- A slip control moves data relative to fr so the receiver's bitslip alignment can be exercised.

Parameters:
- DW, 16, sample width; fixed at 2*SLOTS.
- SLOTS, 8, bit slots per frame.
- IDLE_WORD, 16'h0000, word transmitted when no sample is available.

Ports:
- sys_clk  in  1  slot clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- s_data  in  DW  sample to transmit.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block can accept a sample.
- slip  in  1  one-cycle pulse; advances the data/frame offset by one slot.
- out_a  out  1  lane A: even-position MSB bits.
- out_b  out  1  lane B: odd-position bits.
- dco  out  1  bit clock; toggles every cycle.
- fr  out  1  frame clock; high for slots 0..3, low for slots 4..7.
- frame_start  out  1  pulse aligned with slot 0 on the outputs.
- offset  out  3  current data offset in slots, 0..7.
- underflow_cnt  out  16  saturating count of frames that sent IDLE_WORD.

Behaviour:
- Reset values: all outputs 0, except s_ready=1. slot_cnt=0, holding buffer empty, cur/prev words = IDLE_WORD, offset=0, any pending slip cleared.
- slot_cnt increments every cycle and wraps 7->0. The load cycle is slot_cnt==0.
- Holding buffer (1 entry): s_ready = ~buf_full, driven from a register. A sample is accepted when s_valid & s_ready.
- Load cycle:
  - prev <= cur.
  - cur <= buffer if buf_full, else IDLE_WORD and underflow_cnt++ (saturates at 16'hFFFF).
  - The buffer empties, so s_ready=1 the next cycle.
- Same-cycle accept and load with the buffer empty: the sample enters the buffer, this frame is IDLE_WORD, and the underflow is counted.
- Bit mapping at offset 0, slot k:
  - out_a = cur[DW-1-2k]
  - out_b = cur[DW-2-2k]
  - MSB first; lane A carries bits 15,13,…,1 and lane B carries bits 14,12,…,0.
- Nonzero offset o: the bit pair is taken from the 32-bit stream {prev,cur} delayed by o slots. Slots k<o carry prev's last o bit pairs; the remaining slots carry cur's leading pairs.
- Outputs are registered. Latency:
  - A word loaded in cycle L has its first bit pair on the pins at L+1.
  - fr and frame_start change in that same cycle L+1.
- dco: registered, toggles every cycle, so data changes on both dco edges (DDR). After reset deassertion dco first rises at slot 0 of the outputs.
- slip: latched as pending. It applies at the next load cycle (offset <= offset+1 mod 8, wrapping 7->0), then clears.
  - Multiple slip pulses within one frame count as one.
  - A slip arriving in the load cycle itself applies at that load.
- Reset mid-frame: the frame is aborted; the lines go to reset values on the next edge; the buffered sample is discarded.

Optional Feature:
- Macro: LTC_TX_TEST_PATTERN_EN.
- Defined:
  - Adds ports pattern_en (in, 1) and pattern (in, DW).
  - When pattern_en=1 at a load cycle, cur <= pattern. The buffer is not drained and no underflow is counted.
  - s_ready is forced 0 while pattern_en=1.
- Undefined: ports absent; the behaviour above is unchanged.

Decomposition:
- Package ltc_lvds_pkg:
  - DW and SLOTS constants.
  - IDLE_WORD default.
  - Function lane_bits(word, slot) returning the {a,b} pair.
- Natural sub-module: ltc_tx_holdbuf, the 1-entry valid/ready holding register with a drain strobe.

Test Plan:
- Reset, then feed 16'h000D continuously:
  - Per frame, out_a sequence = 0,0,0,0,0,0,1,0 and out_b sequence = 0,0,0,0,0,0,1,1.
  - fr = 1111_0000; dco toggles every cycle.
  - underflow_cnt stays 0 after the first frame.
- s_valid=0 for 3 frames: IDLE_WORD is transmitted; underflow_cnt increases by 3 and counts from reset.
- Hold s_valid high with a new word every cycle: exactly one accept per frame; s_ready is low for 7 of every 8 cycles.
- Single slip pulse with words 16'hFFFF then 16'h0000:
  - offset becomes 1 at the next frame.
  - In the first 0000 frame, slot 0 carries the pair (1,1) from prev; slots 1..7 carry (0,0).
- 8 slips, one per frame: offset wraps 7->0; the output matches the unslipped stream.
- Assert reset at slot 5: next cycle all outputs are 0, s_ready=1, and the pending sample is dropped.
